// File: rtl/triangle_rasterizer.sv
// rtl/triangle_rasterizer.sv - edge-function triangle rasterizer over a clamped bounding box
// Walks the box in raster order, stepping three edge functions incrementally, and streams inside pixels.
module triangle_rasterizer #(
  parameter int                             VERTEX_WIDTH  = 12,
  parameter int                             FB_ADDR_WIDTH = 17,
  parameter logic signed [VERTEX_WIDTH-1:0] FB_WIDTH      = 320,
  parameter logic signed [VERTEX_WIDTH-1:0] FB_HEIGHT     = 240,
  parameter int                             CULL_BACKFACE = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            ready,
  input  logic signed [VERTEX_WIDTH-1:0]  x0,
  input  logic signed [VERTEX_WIDTH-1:0]  y0,
  input  logic signed [VERTEX_WIDTH-1:0]  x1,
  input  logic signed [VERTEX_WIDTH-1:0]  y1,
  input  logic signed [VERTEX_WIDTH-1:0]  x2,
  input  logic signed [VERTEX_WIDTH-1:0]  y2,
  output logic [FB_ADDR_WIDTH-1:0]        fb_addr,
  output logic [VERTEX_WIDTH-1:0]         fb_x,
  output logic [VERTEX_WIDTH-1:0]         fb_y,
  output logic                            fb_write_enable,
  input  logic                            fb_ready,
  output logic                            busy,
  output logic                            done
);
  localparam int EW = 2*VERTEX_WIDTH + 2;
  typedef logic signed [VERTEX_WIDTH-1:0] coord_t;
  typedef logic signed [EW-1:0]           edge_t;
  typedef logic [FB_ADDR_WIDTH-1:0]       addr_t;
  typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, FINISH} state_t;

  localparam coord_t X_LAST     = FB_WIDTH - coord_t'(1);
  localparam coord_t Y_LAST     = FB_HEIGHT - coord_t'(1);
  localparam addr_t  ROW_STRIDE = addr_t'(FB_WIDTH);

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic edge_t edge_fn(coord_t ax, coord_t ay, coord_t bx, coord_t by,
                                    coord_t px, coord_t py);
    edge_t dx, dy, qx, qy;
    dx = edge_t'(bx) - edge_t'(ax);
    dy = edge_t'(by) - edge_t'(ay);
    qx = edge_t'(px) - edge_t'(ax);
    qy = edge_t'(py) - edge_t'(ay);
    return dx*qy - dy*qx;
  endfunction

  state_t state;
  coord_t vx [3];
  coord_t vy [3];
  coord_t min_x, max_x, min_y, max_y, x, y;
  logic   neg;
  edge_t  w [3];
  edge_t  rw [3];
  addr_t  addr, row_addr;

  coord_t lo_x, hi_x, lo_y, hi_y;
  logic   box_empty, reject, in_tri, advance;
  edge_t  area;
  edge_t  step_x [3];
  edge_t  step_y [3];
  edge_t  w_init [3];
  addr_t  start_addr;

  always_comb begin
    lo_x = min3(vx[0], vx[1], vx[2]);
    if (lo_x[VERTEX_WIDTH-1]) lo_x = '0;
    lo_y = min3(vy[0], vy[1], vy[2]);
    if (lo_y[VERTEX_WIDTH-1]) lo_y = '0;
    hi_x = max3(vx[0], vx[1], vx[2]);
    if (hi_x > X_LAST) hi_x = X_LAST;
    hi_y = max3(vy[0], vy[1], vy[2]);
    if (hi_y > Y_LAST) hi_y = Y_LAST;
    box_empty  = (lo_x > hi_x) || (lo_y > hi_y);
    area       = edge_fn(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
    reject     = box_empty || (area == '0) || ((CULL_BACKFACE != 0) && area[EW-1]);
    start_addr = addr_t'(min_y) * ROW_STRIDE + addr_t'(min_x);
    advance    = !(fb_write_enable && !fb_ready);
    in_tri     = 1'b1;
    // Edge i runs from vertex (i+1)%3 to (i+2)%3, so w2 carries the same sign as area.
    for (int i = 0; i < 3; i++) begin
      step_x[i] = edge_t'(vy[(i+1)%3]) - edge_t'(vy[(i+2)%3]);
      step_y[i] = edge_t'(vx[(i+2)%3]) - edge_t'(vx[(i+1)%3]);
      w_init[i] = edge_fn(vx[(i+1)%3], vy[(i+1)%3], vx[(i+2)%3], vy[(i+2)%3], min_x, min_y);
      if (neg ? (!w[i][EW-1] && (w[i] != '0)) : w[i][EW-1]) in_tri = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ready           <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      fb_write_enable <= 1'b0;
      fb_addr         <= '0;
      fb_x            <= '0;
      fb_y            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          vx[0] <= x0; vy[0] <= y0;
          vx[1] <= x1; vy[1] <= y1;
          vx[2] <= x2; vy[2] <= y2;
          ready <= 1'b0;
          busy  <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          min_x <= lo_x; max_x <= hi_x;
          min_y <= lo_y; max_y <= hi_y;
          neg   <= area[EW-1];
          state <= reject ? FINISH : INIT;
        end
        INIT: begin
          w        <= w_init;
          rw       <= w_init;
          x        <= min_x;
          y        <= min_y;
          addr     <= start_addr;
          row_addr <= start_addr;
          state    <= SCAN;
        end
        SCAN: if (advance) begin
          fb_write_enable <= in_tri;
          fb_x            <= x;
          fb_y            <= y;
          fb_addr         <= addr;
          if (x == max_x) begin
            if (y == max_y) begin
              state <= FINISH;
            end else begin
              x        <= min_x;
              y        <= y + coord_t'(1);
              row_addr <= row_addr + ROW_STRIDE;
              addr     <= row_addr + ROW_STRIDE;
              for (int i = 0; i < 3; i++) begin
                w[i]  <= rw[i] + step_y[i];
                rw[i] <= rw[i] + step_y[i];
              end
            end
          end else begin
            x    <= x + coord_t'(1);
            addr <= addr + addr_t'(1);
            for (int i = 0; i < 3; i++) w[i] <= w[i] + step_x[i];
          end
        end
        // Wait here until the final pixel, if any, has been taken downstream.
        FINISH: if (advance) begin
          fb_write_enable <= 1'b0;
          done            <= 1'b1;
          busy            <= 1'b0;
          ready           <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_rasterizer.sv
// tb/tb_triangle_rasterizer.sv - directed bench for triangle_rasterizer
module tb_triangle_rasterizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, start_c, fb_ready, fb_ready_c;
  logic signed [11:0] x0, y0, x1, y1, x2, y2;
  logic               ready, busy, done, fb_write_enable;
  logic [16:0]        fb_addr;
  logic [11:0]        fb_x, fb_y;
  logic               ready_c, busy_c, done_c, we_c;
  logic [16:0]        fb_addr_c;
  logic [11:0]        fb_x_c, fb_y_c;

  triangle_rasterizer #(.CULL_BACKFACE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .fb_addr(fb_addr), .fb_x(fb_x), .fb_y(fb_y), .fb_write_enable(fb_write_enable),
    .fb_ready(fb_ready), .busy(busy), .done(done)
  );

  triangle_rasterizer #(.CULL_BACKFACE(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .ready(ready_c),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .fb_addr(fb_addr_c), .fb_x(fb_x_c), .fb_y(fb_y_c), .fb_write_enable(we_c),
    .fb_ready(fb_ready_c), .busy(busy_c), .done(done_c)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_tri [10];
  logic [16:0] got_addr [$];
  logic [11:0] got_x [$];
  logic [11:0] got_y [$];
  int          done_cnt, done_cyc, last_wr_cyc, hold_err;
  bit          timed_out;
  logic        rdy_after;
  int          c_wr, c_done_cnt, c_done_cyc;

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int stall);
    int          waits, post;
    bit          pend;
    logic [16:0] pa;
    logic [11:0] px, py;
    got_addr.delete(); got_x.delete(); got_y.delete();
    done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; hold_err = 0; timed_out = 0; rdy_after = 1'bx;
    pa = '0; px = '0; py = '0;
    @(negedge clk);
    x0 = 12'(ax); y0 = 12'(ay); x1 = 12'(bx); y1 = 12'(by); x2 = 12'(cx); y2 = 12'(cy);
    start = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pend = 0; waits = 0; post = -1;
    for (int c = 1; c < 400; c++) begin
      if (post == 1) rdy_after = ready;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (post < 0) post = 0;
      end
      if (fb_write_enable) begin
        if (pend) begin
          if (fb_addr !== pa || fb_x !== px || fb_y !== py) hold_err++;
        end else begin
          pa = fb_addr; px = fb_x; py = fb_y; waits = 0;
        end
        if (waits < stall) begin
          fb_ready = 1'b0; waits++; pend = 1;
        end else begin
          fb_ready = 1'b1; pend = 0;
          got_addr.push_back(fb_addr); got_x.push_back(fb_x); got_y.push_back(fb_y);
          last_wr_cyc = c;
        end
      end else begin
        fb_ready = 1'b1; pend = 0;
      end
      if (post >= 0) post++;
      if (post > 5) break;
      @(negedge clk);
    end
    fb_ready = 1'b1;
    if (post < 0) timed_out = 1;
  endtask

  task automatic run_tri_c(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
    int post;
    @(negedge clk);
    x0 = 12'(ax); y0 = 12'(ay); x1 = 12'(bx); y1 = 12'(by); x2 = 12'(cx); y2 = 12'(cy);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    c_wr = 0; c_done_cnt = 0; c_done_cyc = -1; post = -1;
    for (int c = 1; c < 100; c++) begin
      if (we_c) c_wr++;
      if (done_c) begin
        c_done_cnt++;
        if (c_done_cyc < 0) c_done_cyc = c;
        if (post < 0) post = 0;
      end
      if (post >= 0) post++;
      if (post > 4) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_c = 1'b0; fb_ready = 1'b1; fb_ready_c = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (fb_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", fb_write_enable); end
    n_checks++; if (fb_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", fb_addr); end
    n_checks++; if (fb_x !== 12'd0 || fb_y !== 12'd0) begin n_fail++; $display("FAIL reset_xy got %0d,%0d exp 0,0", fb_x, fb_y); end
    n_checks++; if (ready_c !== 1'b1) begin n_fail++; $display("FAIL reset_ready_cull got %b exp 1", ready_c); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_tri(0, 0, 3, 0, 0, 3, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got no done exp done"); end
    n_checks++; if (got_addr.size() != 10) begin n_fail++; $display("FAIL basic_count got %0d exp 10", got_addr.size()); end
    for (int i = 0; i < 10 && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_tri[i] || got_x[i] !== 12'(exp_tri[i] % 320) || got_y[i] !== 12'(exp_tri[i] / 320)) begin
        n_fail++;
        $display("FAIL basic_pix%0d got %0d (%0d,%0d) exp %0d (%0d,%0d)", i, got_addr[i], got_x[i], got_y[i],
                 exp_tri[i], exp_tri[i] % 320, exp_tri[i] / 320);
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    n_checks++; if (done_cyc != 20) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp 20", done_cyc); end
    n_checks++; if (last_wr_cyc >= done_cyc) begin n_fail++; $display("FAIL basic_done_order got last write %0d done %0d exp write before done", last_wr_cyc, done_cyc); end
  endtask

  task automatic test_reversed();
    run_tri(0, 0, 0, 3, 3, 0, 0);
    n_checks++; if (got_addr.size() != 10 || done_cnt != 1) begin n_fail++; $display("FAIL rev_count got %0d writes %0d done exp 10 writes 1 done", got_addr.size(), done_cnt); end
    for (int i = 0; i < 10 && i < got_addr.size(); i++) begin
      n_checks++; if (got_addr[i] !== exp_tri[i]) begin n_fail++; $display("FAIL rev_addr%0d got %0d exp %0d", i, got_addr[i], exp_tri[i]); end
    end
  endtask

  task automatic test_cull();
    run_tri_c(0, 0, 0, 3, 3, 0);
    n_checks++; if (c_wr != 0) begin n_fail++; $display("FAIL cull_back_writes got %0d exp 0", c_wr); end
    n_checks++; if (c_done_cyc != 3 || c_done_cnt != 1) begin n_fail++; $display("FAIL cull_back_done got cycle %0d count %0d exp cycle 3 count 1", c_done_cyc, c_done_cnt); end
    run_tri_c(0, 0, 3, 0, 0, 3);
    n_checks++; if (c_wr != 10 || c_done_cnt != 1) begin n_fail++; $display("FAIL cull_front got %0d writes %0d done exp 10 writes 1 done", c_wr, c_done_cnt); end
  endtask

  task automatic test_degenerate();
    run_tri(0, 0, 2, 2, 4, 4, 0);
    n_checks++; if (got_addr.size() != 0) begin n_fail++; $display("FAIL degen_writes got %0d exp 0", got_addr.size()); end
    n_checks++; if (done_cyc != 3 || done_cnt != 1) begin n_fail++; $display("FAIL degen_done got cycle %0d count %0d exp cycle 3 count 1", done_cyc, done_cnt); end
    n_checks++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL degen_ready got %b exp 1", rdy_after); end
  endtask

  task automatic test_clip();
    run_tri(-5, -5, 5, -5, -5, 5, 0);
    n_checks++; if (got_addr.size() != 1 || done_cnt != 1) begin n_fail++; $display("FAIL clip_count got %0d writes %0d done exp 1 write 1 done", got_addr.size(), done_cnt); end
    if (got_addr.size() > 0) begin
      n_checks++; if (got_addr[0] !== 17'd0 || got_x[0] !== 12'd0 || got_y[0] !== 12'd0) begin n_fail++; $display("FAIL clip_pixel got %0d (%0d,%0d) exp 0 (0,0)", got_addr[0], got_x[0], got_y[0]); end
    end
    run_tri(400, 10, 410, 10, 400, 20, 0);
    n_checks++; if (got_addr.size() != 0) begin n_fail++; $display("FAIL offscreen_writes got %0d exp 0", got_addr.size()); end
    n_checks++; if (done_cnt != 1 || done_cyc != 3) begin n_fail++; $display("FAIL offscreen_done got count %0d cycle %0d exp count 1 cycle 3", done_cnt, done_cyc); end
  endtask

  task automatic test_backpressure();
    run_tri(0, 0, 3, 0, 0, 3, 3);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got no done exp done"); end
    n_checks++; if (got_addr.size() != 10) begin n_fail++; $display("FAIL bp_count got %0d exp 10", got_addr.size()); end
    for (int i = 0; i < 10 && i < got_addr.size(); i++) begin
      n_checks++; if (got_addr[i] !== exp_tri[i]) begin n_fail++; $display("FAIL bp_addr%0d got %0d exp %0d", i, got_addr[i], exp_tri[i]); end
    end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold got %0d changes exp 0", hold_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int n, dn;
    n = 0; dn = 0;
    @(negedge clk);
    x0 = 12'sd0; y0 = 12'sd0; x1 = 12'sd3; y1 = 12'sd0; x2 = 12'sd0; y2 = 12'sd3;
    start = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (fb_write_enable) n++;
      if (n == 4) break;
      @(negedge clk);
    end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL rmid_writes got %0d exp 4", n); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (fb_write_enable !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_state got we=%b ready=%b busy=%b exp we=0 ready=1 busy=0", fb_write_enable, ready, busy);
    end
    repeat (5) begin
      if (done) dn++;
      @(negedge clk);
    end
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL rmid_no_done got %0d pulses exp 0", dn); end
    run_tri(0, 0, 1, 0, 0, 1, 0);
    n_checks++; if (got_addr.size() != 3 || done_cnt != 1) begin n_fail++; $display("FAIL rmid_next_count got %0d writes %0d done exp 3 writes 1 done", got_addr.size(), done_cnt); end
    if (got_addr.size() == 3) begin
      n_checks++; if (got_addr[0] !== 17'd0 || got_addr[1] !== 17'd1 || got_addr[2] !== 17'd320) begin
        n_fail++; $display("FAIL rmid_next_addr got %0d,%0d,%0d exp 0,1,320", got_addr[0], got_addr[1], got_addr[2]);
      end
    end
  endtask

  initial begin
    exp_tri = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd320, 17'd321, 17'd322, 17'd640, 17'd641, 17'd960};
    test_reset();
    test_basic();
    test_reversed();
    test_cull();
    test_degenerate();
    test_clip();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/triangle_rasterizer.md
Name: triangle_rasterizer

Overview:
- Edge-function triangle rasterizer; successor to the bounding-box fill rasterizer.
- Accepts one screen-space triangle per start/ready handshake and clamps its bounding box to the framebuffer.
- Emits only pixels inside the triangle, with coordinates and linear framebuffer address, under a valid/ready backpressure handshake.
- Sits between the vertex transform stage and the framebuffer/depth write stage; supports either winding order, optional back-face culling, and a multi-triangle stream without reset.

Parameters:
- VERTEX_WIDTH, 12, signed width of vertex coordinates and internal x/y counters.
- FB_ADDR_WIDTH, 17, framebuffer address width.
- FB_WIDTH, 320, framebuffer width in pixels (signed VERTEX_WIDTH).
- FB_HEIGHT, 240, framebuffer height in pixels (signed VERTEX_WIDTH).
- CULL_BACKFACE, 0, 1 = discard triangles with negative area (clockwise in the area convention below).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  triangle valid; accepted when start && ready
- ready  out  1  high in IDLE only
- x0,y0,x1,y1,x2,y2  in  VERTEX_WIDTH each  signed vertex coordinates; sampled on acceptance
- fb_addr  out  FB_ADDR_WIDTH  pixel address, y*FB_WIDTH+x
- fb_x, fb_y  out  VERTEX_WIDTH each  pixel coordinates
- fb_write_enable  out  1  pixel valid
- fb_ready  in  1  downstream accepts the pixel when fb_write_enable && fb_ready
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse per accepted triangle

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ready=1; busy=0; done=0; fb_write_enable=0; fb_addr=0; fb_x=0; fb_y=0. Reset mid-triangle abandons it; no done pulse is generated.
- States: IDLE, SETUP, INIT, SCAN, FINISH.
- IDLE: ready=1. On start, register the vertices, then go to SETUP.
- SETUP:
  - Bounding box uses signed min/max of the vertices, clamped to [0,FB_WIDTH-1] x [0,FB_HEIGHT-1].
  - The box is empty if min_x>max_x or min_y>max_y. The box is inclusive, so single-row or single-column boxes are valid.
  - Edge function: edge(a,b,p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x).
  - area = edge(v0,v1,v2).
  - Go to FINISH if: the box is empty, area==0, or (CULL_BACKFACE && area<0). Otherwise go to INIT.
  - Latch neg = (area<0).
- INIT:
  - w0=edge(v1,v2,p), w1=edge(v2,v0,p), w2=edge(v0,v1,p), evaluated at p=(min_x,min_y). Store them as row-start and current values.
  - Set row_addr = min_y*FB_WIDTH+min_x (the only multiply). Set x=min_x, y=min_y.
- SCAN:
  - Edge arithmetic is signed, 2*VERTEX_WIDTH+2 bits, never overflows.
  - inside = all wi>=0 if !neg; all wi<=0 if neg. Edges with wi==0 are inclusive.
  - Each advancing cycle:
    - If inside, register fb_write_enable=1 with fb_x/fb_y/fb_addr of the pixel; otherwise register fb_write_enable=0.
    - Then step in raster order: x+1 and wi += -(b.y-a.y).
    - At x==max_x: x=min_x, y+1, wi = row_wi + (b.x-a.x), row_addr += FB_WIDTH.
  - Stall: while fb_write_enable && !fb_ready, all scan state and outputs hold stable.
  - Throughput: one pixel position per cycle when unstalled.
  - After the last position (max_x,max_y) is evaluated and its write (if any) is accepted, go to FINISH.
- FINISH:
  - fb_write_enable=0, done=1 for exactly one cycle, busy=0.
  - Next state IDLE, with ready=1 the following cycle.
- Addresses are strictly increasing within a triangle, and each is emitted exactly once.
- Address arithmetic wraps modulo 2^FB_ADDR_WIDTH. Sizing FB_ADDR_WIDTH is the integrator's responsibility.
- start while busy is ignored.

Test Plan:
- Triangle (0,0),(3,0),(0,3), fb_ready=1 -> 10 writes in order: addr 0,1,2,3,320,321,322,640,641,960. done pulses once after the last write; no other writes.
- Reversed winding (0,0),(0,3),(3,0):
  - CULL_BACKFACE=0 -> the same 10 addresses.
  - CULL_BACKFACE=1 -> zero writes; done 3 cycles after acceptance.
- Degenerate collinear (0,0),(2,2),(4,4) -> zero writes; done 3 cycles after acceptance; ready the next cycle.
- Clipping:
  - (-5,-5),(5,-5),(-5,5) -> exactly one write: addr 0, (0,0).
  - (400,10),(410,10),(400,20) -> zero writes; done.
- Backpressure: first scenario with fb_ready deasserted for 3 cycles on every presented pixel -> same 10 addresses in the same order. Each is held stable while stalled; no duplicates or drops.
- Reset after the 4th write of the first scenario -> next cycle fb_write_enable=0, ready=1, busy=0, no done pulse. A following start with (0,0),(1,0),(0,1) yields addr 0,1,320, then done.
